// File: rtl/factor_pkg.sv
// Shared types for the factorization-game answer entry: FSM states, verdict codes, BCD digit.
package factor_pkg;

  typedef enum logic [1:0] {
    ST_EDIT = 2'd0,
    ST_WAIT = 2'd1,
    ST_SHOW = 2'd2
  } state_t;

  localparam logic [1:0] RESULT_NONE    = 2'b00;
  localparam logic [1:0] RESULT_OK      = 2'b01;
  localparam logic [1:0] RESULT_NG      = 2'b10;
  localparam logic [1:0] RESULT_TIMEOUT = 2'b11;

  typedef logic [3:0] bcd_digit_t;

  // Bits needed to count 0..limit-1, never less than one bit.
  function automatic int cnt_width(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/bcd_field_counter.sv
// One answer field of DIGITS BCD digits with wrapping increment/decrement and synchronous clear.
module bcd_field_counter
  import factor_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_inc,
  input  logic                  i_dec,
  input  logic                  i_clr,
  output logic [DIGITS*4-1:0]   o_value
);

  bcd_digit_t r_digits [DIGITS];
  bcd_digit_t w_next   [DIGITS];

  // A digit moves only when every lower digit is at its wrap point (9 for inc, 0 for dec).
  always_comb begin : next_value
    logic v_carry;
    v_carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      w_next[i] = r_digits[i];
      if (i_inc && v_carry) begin
        w_next[i] = (r_digits[i] == 4'd9) ? 4'd0 : bcd_digit_t'(r_digits[i] + 4'd1);
        v_carry   = (r_digits[i] == 4'd9);
      end else if (i_dec && v_carry) begin
        w_next[i] = (r_digits[i] == 4'd0) ? 4'd9 : bcd_digit_t'(r_digits[i] - 4'd1);
        v_carry   = (r_digits[i] == 4'd0);
      end else begin
        v_carry   = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      for (int i = 0; i < DIGITS; i++) r_digits[i] <= 4'd0;
    end else if (i_inc ^ i_dec) begin
      for (int i = 0; i < DIGITS; i++) r_digits[i] <= w_next[i];
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_out
    assign o_value[g*4 +: 4] = r_digits[g];
  end

endmodule

// File: rtl/bcd_answer_entry.sv
// Answer-entry engine: N_FIELDS BCD fields, cursor, submit/verdict handshake and verdict display.
// Optional cursor blink on BLANK_OUT is enabled by defining CURSOR_BLINK_EN.
module bcd_answer_entry
  import factor_pkg::*;
#(
  parameter int N_FIELDS    = 3,
  parameter int DIGITS      = 2,
  parameter int SHOW_CYC    = 50_000_000,
  parameter int CHK_TIMEOUT = 1024,
  parameter int BLINK_CYC   = 12_500_000
) (
  input  logic                                          CLK,
  input  logic                                          RST,
  input  logic                                          SEL_IN,
  input  logic                                          INC_IN,
  input  logic                                          DEC_IN,
  input  logic                                          SUBMIT_IN,
  input  logic                                          CLR_IN,
  input  logic                                          CHK_DONE,
  input  logic                                          CHK_OK,
  output logic [N_FIELDS*DIGITS*4-1:0]                  FIELDS_OUT,
  output logic [((N_FIELDS > 1) ? $clog2(N_FIELDS) : 1)-1:0] CURSOR_OUT,
  output logic                                          CHK_REQ,
  output logic [1:0]                                    RESULT_OUT,
  output logic [N_FIELDS*DIGITS-1:0]                    BLANK_OUT
);

  localparam int CUR_W  = cnt_width(N_FIELDS);
  localparam int WAIT_W = cnt_width(CHK_TIMEOUT);
  localparam int SHOW_W = cnt_width(SHOW_CYC);
  localparam logic [CUR_W-1:0]  LAST_FIELD = CUR_W'(N_FIELDS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(CHK_TIMEOUT - 1);
  localparam logic [SHOW_W-1:0] SHOW_LAST  = SHOW_W'(SHOW_CYC - 1);

  if (N_FIELDS < 1 || DIGITS < 1 || SHOW_CYC < 1 || CHK_TIMEOUT < 1 || BLINK_CYC < 1) begin : g_bad_param
    $error("bcd_answer_entry: all parameters must be >= 1");
  end

  state_t             r_state;
  logic [CUR_W-1:0]   r_cursor;
  logic               r_chk_req;
  logic [1:0]         r_result;
  logic [WAIT_W-1:0]  r_wait_cnt;
  logic [SHOW_W-1:0]  r_show_cnt;

  logic w_edit;
  logic w_key_inc;
  logic w_key_dec;
  logic w_show_done;
  logic w_clr_fields;

  // Key priority CLR > SUBMIT > SEL > INC/DEC; INC with DEC cancels out.
  assign w_edit       = (r_state == ST_EDIT);
  assign w_key_inc    = w_edit && !CLR_IN && !SUBMIT_IN && !SEL_IN && INC_IN && !DEC_IN;
  assign w_key_dec    = w_edit && !CLR_IN && !SUBMIT_IN && !SEL_IN && DEC_IN && !INC_IN;
  assign w_show_done  = (r_state == ST_SHOW) && (r_show_cnt == SHOW_LAST);
  assign w_clr_fields = CLR_IN || (w_show_done && (r_result == RESULT_OK));

  for (genvar f = 0; f < N_FIELDS; f++) begin : g_field
    bcd_field_counter #(.DIGITS(DIGITS)) u_field (
      .i_clk   (CLK),
      .i_rst_n (RST),
      .i_inc   (w_key_inc && (r_cursor == CUR_W'(f))),
      .i_dec   (w_key_dec && (r_cursor == CUR_W'(f))),
      .i_clr   (w_clr_fields),
      .o_value (FIELDS_OUT[f*DIGITS*4 +: DIGITS*4])
    );
  end

  always_ff @(posedge CLK) begin
    if (!RST || CLR_IN) begin
      r_state    <= ST_EDIT;
      r_cursor   <= '0;
      r_chk_req  <= 1'b0;
      r_result   <= RESULT_NONE;
      r_wait_cnt <= '0;
      r_show_cnt <= '0;
    end else begin
      case (r_state)
        ST_EDIT: begin
          if (SUBMIT_IN) begin
            r_state    <= ST_WAIT;
            r_chk_req  <= 1'b1;
            r_wait_cnt <= '0;
          end else if (SEL_IN) begin
            r_cursor <= (r_cursor == LAST_FIELD) ? '0 : r_cursor + CUR_W'(1);
          end
        end
        ST_WAIT: begin
          if (CHK_DONE) begin
            r_state    <= ST_SHOW;
            r_chk_req  <= 1'b0;
            r_result   <= CHK_OK ? RESULT_OK : RESULT_NG;
            r_show_cnt <= '0;
          end else if (r_wait_cnt == WAIT_LAST) begin
            r_state    <= ST_SHOW;
            r_chk_req  <= 1'b0;
            r_result   <= RESULT_TIMEOUT;
            r_show_cnt <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end
        ST_SHOW: begin
          if (r_show_cnt == SHOW_LAST) begin
            r_state  <= ST_EDIT;
            r_result <= RESULT_NONE;
            if (r_result == RESULT_OK) r_cursor <= '0;
          end else begin
            r_show_cnt <= r_show_cnt + SHOW_W'(1);
          end
        end
        default: r_state <= ST_EDIT;
      endcase
    end
  end

  assign CURSOR_OUT = r_cursor;
  assign CHK_REQ    = r_chk_req;
  assign RESULT_OUT = r_result;

`ifdef CURSOR_BLINK_EN
  localparam int BLINK_W = cnt_width(BLINK_CYC);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYC - 1);

  logic [BLINK_W-1:0]          r_blink_cnt;
  logic                        r_blink_phase;
  logic [N_FIELDS*DIGITS-1:0]  w_blank;

  // Phase 0 = shown; any editing key or leaving EDIT restarts in the shown phase.
  always_ff @(posedge CLK) begin
    if (!RST || !w_edit || CLR_IN || SEL_IN || INC_IN || DEC_IN) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_blink_cnt == BLINK_LAST) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
    end
  end

  always_comb begin
    w_blank = '0;
    for (int f = 0; f < N_FIELDS; f++) begin
      if (w_edit && r_blink_phase && (r_cursor == CUR_W'(f))) w_blank[f*DIGITS +: DIGITS] = '1;
    end
  end

  assign BLANK_OUT = w_blank;
`else
  assign BLANK_OUT = '0;
`endif

endmodule

// File: tb/tb_bcd_answer_entry.sv
// Bench for bcd_answer_entry: edit vector table with expected queue, then handshake/timeout/clear/blink sequences.
module tb_bcd_answer_entry;

  localparam int N_F   = 3;
  localparam int DIG   = 2;
  localparam int SHOW  = 20;
  localparam int TMO   = 16;
  localparam int BLINK = 4;
  localparam int FW    = N_F * DIG * 4;
  localparam int CW    = 2;
  localparam int NVEC  = 18;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            sel, inc, dec, sub, clr, chk_done, chk_ok;
  logic [FW-1:0]   fields;
  logic [CW-1:0]   cursor;
  logic            chk_req;
  logic [1:0]      result;
  logic [N_F*DIG-1:0] blank;

  always #5 clk = ~clk;

  bcd_answer_entry #(
    .N_FIELDS(N_F), .DIGITS(DIG), .SHOW_CYC(SHOW), .CHK_TIMEOUT(TMO), .BLINK_CYC(BLINK)
  ) dut (
    .CLK(clk), .RST(rst_n), .SEL_IN(sel), .INC_IN(inc), .DEC_IN(dec), .SUBMIT_IN(sub),
    .CLR_IN(clr), .CHK_DONE(chk_done), .CHK_OK(chk_ok), .FIELDS_OUT(fields),
    .CURSOR_OUT(cursor), .CHK_REQ(chk_req), .RESULT_OUT(result), .BLANK_OUT(blank)
  );

  typedef struct packed {
    logic          sel, inc, dec, clr, sub;
    logic [FW-1:0] fields;
    logic [CW-1:0] cursor;
  } vec_t;

  vec_t vecs [NVEC];
  logic [FW+CW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic s, input logic i, input logic d, input logic c, input logic b);
    sel = s; inc = i; dec = d; clr = c; sub = b;
    step();
    sel = 0; inc = 0; dec = 0; clr = 0; sub = 0;
  endtask

  initial begin
    logic [FW+CW-1:0] e;
    int req_cycles;

    //                sel  inc  dec  clr  sub  fields      cursor
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000001, 2'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000002, 2'd0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000003, 2'd0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000002, 2'd0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000002, 2'd0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000002, 2'd1};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h009902, 2'd1};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h009902, 2'd2};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h019902, 2'd2};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h019902, 2'd0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h019902, 2'd1};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h010002, 2'd1};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h019902, 2'd1};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000000, 2'd0};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000099, 2'd0};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000098, 2'd0};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000099, 2'd0};
    vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 2'd0};

    // Clock/reset
    rst_n = 0; sel = 0; inc = 0; dec = 0; sub = 0; clr = 0; chk_done = 0; chk_ok = 0;
    step(); step();
    check("rst_fields", 32'(fields), 32'h0);
    check("rst_cursor", 32'(cursor), 32'h0);
    check("rst_req", 32'(chk_req), 32'h0);
    check("rst_result", 32'(result), 32'h0);
    check("rst_blank", 32'(blank), 32'h0);
    rst_n = 1;
    step();

    // Edit table
    for (int v = 0; v < NVEC; v++) begin
      exp_q.push_back({vecs[v].cursor, vecs[v].fields});
      press(vecs[v].sel, vecs[v].inc, vecs[v].dec, vecs[v].clr, vecs[v].sub);
      if (exp_q.size() == 0) begin
        check("tbl_queue_empty", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("tbl%0d_fields", v), 32'(fields), 32'(e[FW-1:0]));
        check($sformatf("tbl%0d_cursor", v), 32'(cursor), 32'(e[FW+CW-1:FW]));
      end
    end

    // Carry 09 -> 10 and borrow 10 -> 09
    for (int k = 0; k < 10; k++) press(0, 1, 0, 0, 0);
    check("carry_10", 32'(fields), 32'h000010);
    press(0, 0, 1, 0, 0);
    check("borrow_09", 32'(fields), 32'h000009);

    // Submit with OK verdict on the 5th cycle of CHK_REQ
    press(1, 0, 0, 0, 0);
    check("ok_cursor_pre", 32'(cursor), 32'd1);
    press(0, 0, 0, 0, 1);
    check("ok_req_rise", 32'(chk_req), 32'd1);
    req_cycles = 0;
    for (int k = 0; k < 4; k++) begin
      if (chk_req) req_cycles++;
      press(0, 1, 0, 0, 0);
    end
    chk_done = 1; chk_ok = 1;
    if (chk_req) req_cycles++;
    step();
    chk_done = 0; chk_ok = 0;
    check("ok_req_cycles", 32'(req_cycles), 32'd5);
    check("ok_req_drop", 32'(chk_req), 32'd0);
    check("ok_result", 32'(result), 32'b01);
    check("ok_wait_frozen", 32'(fields), 32'h000009);
    press(0, 1, 0, 0, 0);
    for (int k = 0; k < SHOW - 2; k++) step();
    check("ok_show_hold", 32'(result), 32'b01);
    check("ok_show_frozen", 32'(fields), 32'h000009);
    step();
    check("ok_show_end", 32'(result), 32'b00);
    check("ok_fields_clr", 32'(fields), 32'h0);
    check("ok_cursor_clr", 32'(cursor), 32'd0);

    // NG verdict keeps fields and cursor; stray CHK_DONE in EDIT is ignored
    press(1, 0, 0, 0, 0);
    press(0, 1, 0, 0, 0);
    check("ng_setup", 32'(fields), 32'h000100);
    chk_done = 1; chk_ok = 1;
    step();
    chk_done = 0; chk_ok = 0;
    check("stray_done_result", 32'(result), 32'b00);
    check("stray_done_req", 32'(chk_req), 32'd0);
    press(0, 0, 0, 0, 1);
    chk_done = 1; chk_ok = 0;
    step();
    chk_done = 0;
    check("ng_result", 32'(result), 32'b10);
    check("ng_req_drop", 32'(chk_req), 32'd0);
    for (int k = 0; k < SHOW - 1; k++) step();
    check("ng_show_hold", 32'(result), 32'b10);
    step();
    check("ng_show_end", 32'(result), 32'b00);
    check("ng_fields_kept", 32'(fields), 32'h000100);
    check("ng_cursor_kept", 32'(cursor), 32'd1);

    // Timeout, INC during WAIT ignored, CLR out of SHOW
    press(0, 0, 0, 0, 1);
    check("tmo_req", 32'(chk_req), 32'd1);
    press(0, 1, 0, 0, 0);
    for (int k = 0; k < TMO - 2; k++) step();
    check("tmo_req_hold", 32'(chk_req), 32'd1);
    check("tmo_result_pre", 32'(result), 32'b00);
    check("tmo_wait_frozen", 32'(fields), 32'h000100);
    step();
    check("tmo_result", 32'(result), 32'b11);
    check("tmo_req_drop", 32'(chk_req), 32'd0);
    press(0, 0, 0, 1, 0);
    check("show_clr_result", 32'(result), 32'b00);
    check("show_clr_fields", 32'(fields), 32'h0);
    check("show_clr_cursor", 32'(cursor), 32'd0);

    // CLR during WAIT
    press(0, 1, 0, 0, 0);
    press(0, 0, 0, 0, 1);
    check("wclr_req_pre", 32'(chk_req), 32'd1);
    press(0, 0, 0, 1, 0);
    check("wclr_req", 32'(chk_req), 32'd0);
    check("wclr_fields", 32'(fields), 32'h0);
    check("wclr_result", 32'(result), 32'b00);
    press(0, 1, 0, 0, 0);
    check("wclr_edit", 32'(fields), 32'h000001);

    // Cursor blink on field0
`ifdef CURSOR_BLINK_EN
    for (int k = 0; k < BLINK; k++) begin
      check($sformatf("blink_show%0d", k), 32'(blank), 32'h0);
      step();
    end
    for (int k = 0; k < BLINK; k++) begin
      check($sformatf("blink_blank%0d", k), 32'(blank), 32'h03);
      step();
    end
    check("blink_show_again", 32'(blank), 32'h0);
`else
    for (int k = 0; k < 2 * BLINK; k++) step();
    check("blank_tied", 32'(blank), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
